// File: rtl/debug_page_seq_pkg.sv
// Shared types and display character codes for the debug page sequencer.
// Digit codes: 0-15 hex value, 65-84 ASCII letter, 127 blank.
package dbg_disp_pkg;

  typedef enum logic [2:0] {
    P_CC = 3'd0,
    P_PC = 3'd1,
    P_AD = 3'd2,
    P_IN = 3'd3,
    P_ST = 3'd4,
    P_OP = 3'd5
  } page_t;

  localparam logic [7:0] CH_A     = 8'd65;
  localparam logic [7:0] CH_C     = 8'd67;
  localparam logic [7:0] CH_D     = 8'd68;
  localparam logic [7:0] CH_I     = 8'd73;
  localparam logic [7:0] CH_N     = 8'd78;
  localparam logic [7:0] CH_O     = 8'd79;
  localparam logic [7:0] CH_P     = 8'd80;
  localparam logic [7:0] CH_S     = 8'd83;
  localparam logic [7:0] CH_T     = 8'd84;
  localparam logic [7:0] CH_BLANK = 8'd127;

  typedef struct packed {
    logic [15:0] cc;
    logic [15:0] pc;
    logic [15:0] ad;
    logic [7:0]  ir;
    logic [3:0]  st;
    logic [7:0]  op;
  } snap_t;

  // Two-letter label for the left digit pair; unknown pages show blanks.
  function automatic logic [1:0][7:0] page_label(page_t p);
    case (p)
      P_CC:    page_label = {CH_C, CH_C};
      P_PC:    page_label = {CH_P, CH_C};
      P_AD:    page_label = {CH_A, CH_D};
      P_IN:    page_label = {CH_I, CH_N};
      P_ST:    page_label = {CH_S, CH_T};
      P_OP:    page_label = {CH_O, CH_P};
      default: page_label = {CH_BLANK, CH_BLANK};
    endcase
  endfunction

endpackage

// File: rtl/debug_page_seq_if.sv
// Bundle of CPU debug inputs, key/hold controls and display outputs.
interface debug_page_seq_if;
  logic             key_n;
  logic             hold;
  logic [15:0]      cc;
  logic [15:0]      pc;
  logic [15:0]      ad;
  logic [7:0]       ir;
  logic [3:0]       st;
  logic [7:0]       op;
  logic [5:0][7:0]  dig;
  logic [2:0]       page;

  modport master (output key_n, hold, cc, pc, ad, ir, st, op, input dig, page);
  modport slave  (input key_n, hold, cc, pc, ad, ir, st, op, output dig, page);
endinterface

// File: rtl/debug_page_seq_key_debounce.sv
// Key conditioning: 2-flop synchronizer, level debounce, press pulse on release->pressed.
module key_debounce #(
  parameter int DB_CYC = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DB_CYC + 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          synced;

  assign synced  = sync_q[1];
  assign press_o = press_q;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        stable_d = synced;
        press_d  = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end
endmodule

// File: rtl/debug_page_seq.sv
// Debug display page sequencer: snapshots CPU values, steps pages on key press,
// and emits six digit codes. Optional auto-rotate under DBG_AUTO_ROTATE_EN.
module debug_page_seq
  import dbg_disp_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int ROTATE_MS   = 2000
) (
  input  logic              clk,
  input  logic              reset,
  debug_page_seq_if.slave   bus
);
  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;

  logic            press, advance;
  page_t           page_q, page_d;
  snap_t           snap_q, snap_d;
  logic [5:0][7:0] dig_q, dig_d;

  key_debounce #(.DB_CYC(DB_CYC)) u_key (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (bus.key_n),
    .press_o (press)
  );

`ifdef DBG_AUTO_ROTATE_EN
  localparam int ROT_CYC = CLK_HZ / 1000 * ROTATE_MS;
  localparam int RW      = $clog2(ROT_CYC + 1);

  logic [RW-1:0] rot_q, rot_d;
  logic          tick;

  assign tick    = (rot_q == RW'(ROT_CYC - 1));
  assign rot_d   = (press || tick) ? '0 : rot_q + 1'b1;
  assign advance = press | tick;

  always_ff @(posedge clk) begin
    if (reset) rot_q <= '0;
    else       rot_q <= rot_d;
  end
`else
  assign advance = press;
`endif

  // Hold freezes the snapshot only; page stepping is unaffected.
  always_comb begin
    snap_d = snap_q;
    if (!bus.hold) snap_d = '{cc: bus.cc, pc: bus.pc, ad: bus.ad,
                              ir: bus.ir, st: bus.st, op: bus.op};
  end

  always_comb begin
    page_d = page_q;
    case (page_q)
      P_CC:    if (advance) page_d = P_PC;
      P_PC:    if (advance) page_d = P_AD;
      P_AD:    if (advance) page_d = P_IN;
      P_IN:    if (advance) page_d = P_ST;
      P_ST:    if (advance) page_d = P_OP;
      P_OP:    if (advance) page_d = P_CC;
      default: page_d = P_CC;
    endcase
  end

  always_comb begin
    dig_d      = {6{CH_BLANK}};
    dig_d[5:4] = page_label(page_q);
    case (page_q)
      P_CC: for (int i = 0; i < 4; i++) dig_d[i] = {4'h0, snap_q.cc[4*i +: 4]};
      P_PC: for (int i = 0; i < 4; i++) dig_d[i] = {4'h0, snap_q.pc[4*i +: 4]};
      P_AD: for (int i = 0; i < 4; i++) dig_d[i] = {4'h0, snap_q.ad[4*i +: 4]};
      P_IN: for (int i = 0; i < 2; i++) dig_d[i] = {4'h0, snap_q.ir[4*i +: 4]};
      P_OP: for (int i = 0; i < 2; i++) dig_d[i] = {4'h0, snap_q.op[4*i +: 4]};
      P_ST: dig_d[0] = {4'h0, snap_q.st};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_q <= P_CC;
      snap_q <= '0;
      dig_q  <= {6{CH_BLANK}};
    end else begin
      page_q <= page_d;
      snap_q <= snap_d;
      dig_q  <= dig_d;
    end
  end

  assign bus.dig  = dig_q;
  assign bus.page = page_q;
endmodule
